// File: rtl/nubus_pkg.sv
// Shared NuBus definitions: slave data-phase states, acknowledge status codes
// and the transfer-size decode that both slave and master paths use.
package nubus_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_WAIT,
    S_ACK
  } state_t;

  // Status as driven on the active-low /TM1-/TM0 pair during ACK.
  localparam logic [1:0] ST_COMPLETE = 2'b00;
  localparam logic [1:0] ST_ERROR    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;

  // Returns {err, be[3:0]} for the transfer-mode bit and the low address bits
  // (true polarity). Reserved size yields err with no lanes enabled.
  function automatic logic [4:0] size_decode(input logic tm0n, input logic [1:0] a);
    logic [4:0] r;
    r = 5'b1_0000;
    if (tm0n) begin
      r = {1'b0, 4'b0001 << a};
    end else begin
      case (a)
        2'b00:   r = 5'b0_1111;
        2'b10:   r = 5'b0_1100;
        2'b01:   r = 5'b0_0011;
        default: r = 5'b1_0000;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/nubus_be_decode.sv
// Combinational transfer-size decode to byte enables plus reserved-size error.
module nubus_be_decode
  import nubus_pkg::*;
(
  input  logic       tm0n,
  input  logic [1:0] a,
  output logic [3:0] be,
  output logic       err
);

  // Single source of truth lives in the package so the master path matches.
  assign {err, be} = size_decode(tm0n, a);

endmodule

// File: rtl/nubus_slave_dataphase.sv
// NuBus slave data-phase sequencer: captures the address cycle for this slot,
// issues one local memory request, bounds the wait, then drives the ACK cycle.
module nubus_slave_dataphase
  import nubus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_n,
  input  logic        ack_n,
  input  logic        tm1n,
  input  logic        tm0n,
  input  logic [31:0] ad_n,
  input  logic        myslot,
  input  logic        slave,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  output logic        mem_req,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done,
  output logic        mem_ready,
  output logic        ack_out_n,
  output logic        ack_oe,
  output logic [1:0]  tm_out_n,
  output logic        tm_oe,
  output logic [31:0] ad_out_n,
  output logic        ad_oe
);

  localparam int            CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic          err, err_nx;
  logic [31:0]   ad;
  logic [3:0]    dec_be;
  logic          dec_err;

  logic [31:0] addr_nx, wdata_nx, ad_out_n_nx;
  logic [3:0]  be_nx;
  logic        we_nx, req_nx, ready_nx, ad_oe_nx;
  logic        go_ack;
  logic [1:0]  st;

  assign ad = ~ad_n;

  nubus_be_decode u_be_dec (
    .tm0n (tm0n),
    .a    (ad[1:0]),
    .be   (dec_be),
    .err  (dec_err)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    err_nx      = err;
    addr_nx     = mem_addr;
    be_nx       = mem_be;
    we_nx       = mem_we;
    wdata_nx    = mem_wdata;
    req_nx      = mem_req;
    ready_nx    = 1'b0;
    ad_oe_nx    = 1'b0;
    ad_out_n_nx = '1;
    go_ack      = 1'b0;
    st          = ST_COMPLETE;
    cnt_inc     = (cnt == TO_MAX) ? cnt : cnt + 1'b1;
    case (state)
      S_IDLE: begin
        if (!start_n && ack_n && myslot) begin
          addr_nx  = ad;
          we_nx    = tm1n;
          be_nx    = dec_be;
          err_nx   = dec_err;
          state_nx = S_DATA;
        end
      end
      S_DATA: begin
        wdata_nx = ad;
        req_nx   = !err;
        cnt_nx   = '0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (!slave) begin
          // Controller abandoned the cycle: quietly return, no ACK.
          req_nx   = 1'b0;
          state_nx = S_IDLE;
        end else if (err) begin
          go_ack = 1'b1;
          st     = ST_ERROR;
        end else if (mem_done) begin
          // Done wins over a simultaneous timeout.
          req_nx = 1'b0;
          go_ack = 1'b1;
          st     = ST_COMPLETE;
          if (!mem_we) begin
            ad_oe_nx    = 1'b1;
            ad_out_n_nx = ~mem_rdata;
          end
        end else if (cnt_inc == TO_MAX) begin
          req_nx = 1'b0;
          go_ack = 1'b1;
          st     = ST_TIMEOUT;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      S_ACK: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (go_ack) begin
      state_nx = S_ACK;
      ready_nx = 1'b1;
    end
  end

  // State and output registers; reset forces every bus driver off at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_req   <= 1'b0;
      mem_ready <= 1'b0;
      ack_oe    <= 1'b0;
      ack_out_n <= 1'b1;
      tm_oe     <= 1'b0;
      tm_out_n  <= 2'b11;
      ad_oe     <= 1'b0;
      ad_out_n  <= '1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      err       <= err_nx;
      mem_addr  <= addr_nx;
      mem_be    <= be_nx;
      mem_we    <= we_nx;
      mem_wdata <= wdata_nx;
      mem_req   <= req_nx;
      mem_ready <= ready_nx;
      ack_oe    <= go_ack;
      ack_out_n <= !go_ack;
      tm_oe     <= go_ack;
      tm_out_n  <= go_ack ? st : 2'b11;
      ad_oe     <= ad_oe_nx;
      ad_out_n  <= ad_out_n_nx;
    end
  end

endmodule

// File: tb/tb_nubus_slave_dataphase.sv
// Scoreboard bench for nubus_slave_dataphase: the driver pushes expected
// memory requests and acknowledges, independent monitors pop and compare.
module tb_nubus_slave_dataphase;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_n, ack_n, tm1n, tm0n, myslot, slave, mem_done;
  logic [31:0] ad_n, mem_rdata;
  logic [31:0] mem_addr, mem_wdata, ad_out_n;
  logic [3:0]  mem_be;
  logic        mem_we, mem_req, mem_ready, ack_out_n, ack_oe, tm_oe, ad_oe;
  logic [1:0]  tm_out_n;

  nubus_slave_dataphase #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start_n(start_n), .ack_n(ack_n),
    .tm1n(tm1n), .tm0n(tm0n), .ad_n(ad_n), .myslot(myslot), .slave(slave),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_we(mem_we), .mem_req(mem_req),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .mem_ready(mem_ready), .ack_out_n(ack_out_n), .ack_oe(ack_oe),
    .tm_out_n(tm_out_n), .tm_oe(tm_oe), .ad_out_n(ad_out_n), .ad_oe(ad_oe)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } req_t;
  typedef struct { logic [1:0] tm; logic ad_oe; logic [31:0] ad_out_n; } ack_t;

  req_t        req_q[$];
  ack_t        ack_q[$];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] last_addr = '0;
  logic        prev_req = 1'b0;
  req_t        mr;
  ack_t        ma;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ctl"}, {mem_req, mem_we, mem_ready, ack_oe, tm_oe, ad_oe, ack_out_n, tm_out_n},
        9'b000000111);
    chk({nm, "_ad_out"}, ad_out_n, 32'hFFFF_FFFF);
    chk({nm, "_addr"}, mem_addr, 0);
    chk({nm, "_wdata"}, mem_wdata, 0);
    chk({nm, "_be"}, mem_be, 0);
  endtask

  // Memory-side monitor: each rising mem_req must match the next expected request.
  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (mem_req && !prev_req) begin
        if (req_q.size() == 0) chk("unexpected_req", 1, 0);
        else begin
          mr = req_q.pop_front();
          chk("mem_addr", mem_addr, mr.addr);
          chk("mem_be", mem_be, mr.be);
          chk("mem_we", mem_we, mr.we);
          chk("mem_wdata", mem_wdata, mr.wdata);
        end
      end
      prev_req = mem_req;
    end
  end

  // Bus-side monitor: ACK cycle contents, and no drivers enabled otherwise.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_ready) begin
        if (ack_q.size() == 0) chk("unexpected_ack", 1, 0);
        else begin
          ma = ack_q.pop_front();
          chk("ack_drive", {ack_oe, ack_out_n, tm_oe}, 3'b101);
          chk("tm_out_n", tm_out_n, ma.tm);
          chk("ad_oe", ad_oe, ma.ad_oe);
          chk("ad_out_n", ad_out_n, ma.ad_out_n);
          chk("req_dropped", mem_req, 0);
        end
      end else begin
        chk("idle_drive", {ack_oe, tm_oe, ad_oe, ack_out_n, tm_out_n, ad_out_n},
            {6'b000111, 32'hFFFF_FFFF});
      end
    end
  end

  // mode 0: normal, 1: slave dropped in WAIT, 2: reset asserted in WAIT.
  // d = WAIT cycles before mem_done (d >= TO means it never comes in time).
  task automatic txn(input logic [31:0] addr, input logic we, input logic tz,
                     input logic [31:0] wd, input logic [31:0] rd, input int d, input int mode);
    logic       err;
    logic [3:0] be;
    logic [1:0] st;
    int         edges, k, exp_lat;
    bit         got;
    req_t       r;
    ack_t       a;
    err = !tz && (addr[1:0] == 2'b11);
    if (tz) be = 4'b0001 << addr[1:0];
    else if (addr[1:0] == 2'b00) be = 4'b1111;
    else if (addr[1:0] == 2'b10) be = 4'b1100;
    else if (addr[1:0] == 2'b01) be = 4'b0011;
    else be = 4'b0000;
    if (!err) begin
      r = '{addr, be, we, wd};
      req_q.push_back(r);
    end
    st = err ? 2'b01 : (d < TO ? 2'b00 : 2'b10);
    if (mode == 0) begin
      a.tm       = st;
      a.ad_oe    = !we && (st == 2'b00);
      a.ad_out_n = a.ad_oe ? ~rd : 32'hFFFF_FFFF;
      ack_q.push_back(a);
    end
    exp_lat = err ? 2 : 2 + (d < TO ? d : TO - 1);
    last_addr = addr;

    @(negedge clk);
    start_n = 1'b0; ad_n = ~addr; tm1n = we; tm0n = tz; myslot = 1'b1;
    @(negedge clk);
    start_n = 1'b1; myslot = 1'b0; ad_n = ~wd; tm1n = 1'b1; tm0n = 1'b1;
    @(negedge clk);
    ad_n  = '1;
    edges = 1;
    got   = 0;
    while (!got && edges < 60) begin
      k         = edges - 1;
      mem_done  = (mode == 0) && !err && (d < TO) && (k == d);
      mem_rdata = mem_done ? rd : $urandom;
      if (mode == 1 && k == 1) slave = 1'b0;
      if (mode == 2 && k == 1) begin
        #2 reset = 1'b1;
        #1 chk_reset("reset_mid_wait");
        @(negedge clk);
        #2 reset = 1'b0;
        last_addr = '0;
        return;
      end
      @(negedge clk);
      edges++;
      mem_done = 1'b0;
      if (mode == 1 && k == 1) chk("abort_req", mem_req, 0);
      if (mode == 1 && k == 4) begin
        slave = 1'b1;
        return;
      end
      if (mem_ready) got = 1;
    end
    chk("ack_latency", edges, exp_lat);
    @(negedge clk);
    chk("ready_pulse", {mem_ready, ack_oe}, 0);
  endtask

  task automatic null_start(input logic slot, input logic ackn);
    @(negedge clk);
    start_n = 1'b0; ad_n = $urandom; myslot = slot; ack_n = ackn; tm0n = 1'b0; tm1n = 1'b1;
    @(negedge clk);
    start_n = 1'b1; myslot = 1'b0; ack_n = 1'b1; ad_n = '1;
    repeat (4) begin
      @(negedge clk);
      chk("null_outputs", {mem_req, mem_ready, ack_oe}, 0);
    end
    chk("null_addr", mem_addr, last_addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start_n = 1'b1; ack_n = 1'b1; tm1n = 1'b1; tm0n = 1'b1;
    ad_n = '1; myslot = 1'b0; slave = 1'b1; mem_done = 1'b0; mem_rdata = '0;
    @(posedge clk);
    #1 chk_reset("reset_state");
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;

    txn(32'hF000_1000, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 0, 0);     // word write
    txn(32'hF000_0003, 1'b0, 1'b1, 32'h0, 32'hA5A5_A5A5, 5, 0);     // byte read, 5 waits
    txn(32'hF000_2000, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h0, 99, 0);   // timeout
    txn(32'hF000_0013, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);            // reserved size
    txn(32'hF000_0042, 1'b0, 1'b0, 32'h0, 32'h1111_2222, TO - 1, 0); // done at timeout edge
    null_start(1'b0, 1'b1);
    null_start(1'b1, 1'b0);
    txn(32'hF000_3001, 1'b1, 1'b0, 32'h0BAD_BEEF, 32'h0, 99, 1);   // slave dropped
    txn(32'hF000_4002, 1'b0, 1'b0, 32'h0, 32'h3C3C_0FF0, 1, 0);
    txn(32'hF000_5000, 1'b0, 1'b0, 32'h0, 32'h0, 99, 2);           // reset in WAIT
    txn(32'hF000_6000, 1'b0, 1'b1, 32'h0, 32'h7E57_0001, 2, 0);

    for (int i = 0; i < 40; i++) begin
      txn($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
          $urandom_range(0, TO + 2), 0);
    end

    repeat (5) @(negedge clk);
    chk("req_q_empty", req_q.size(), 0);
    chk("ack_q_empty", ack_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nubus_slave_dataphase.md
# nubus_slave_dataphase

Slave data-phase sequencer for the NuBus card. It sits directly downstream of the NuBus slave controller. It captures the address/transfer-mode cycle addressed to this slot and turns it into a single local memory request with byte enables. It waits for the memory with a bounded timeout, then drives the NuBus acknowledge cycle (/ACK, status on /TM1-/TM0, read data on /AD). The `mem_ready` pulse it produces is the one the slave controller consumes to close its SLAVE state.

## Interface
- `TIMEOUT`, default 255: maximum WAIT cycles before a timeout-error acknowledge; 1..65535.
- `clk` in 1: NuBus-derived clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `start_n`, `ack_n` in 1: raw NuBus /START and /ACK.
- `tm1n`, `tm0n` in 1: raw NuBus /TM1, /TM0.
- `ad_n` in 32: raw NuBus /AD, active-low.
- `myslot` in 1: slot decode for the current address.
- `slave` in 1: SLAVE state from the slave controller.
- `mem_addr` out 32: latched address, true polarity.
- `mem_be` out 4: byte enables.
- `mem_we` out 1: 1 means write.
- `mem_req` out 1: request, held until `mem_done` is seen.
- `mem_wdata` out 32: latched write data.
- `mem_rdata` in 32, `mem_done` in 1: memory response, one-cycle pulse.
- `mem_ready` out 1: high for exactly the ACK cycle; feeds the slave controller.
- `ack_out_n`, `ack_oe` out 1: /ACK drive value and output enable.
- `tm_out_n` out 2, `tm_oe` out 1: status drive value and output enable.
- `ad_out_n` out 32, `ad_oe` out 1: read data drive value and output enable.

## Operation
- FSM states: IDLE, DATA, WAIT, ACK.
- IDLE: on an edge with `start_n`=0, `ack_n`=1 and `myslot`=1:
  - latch `mem_addr` = ~`ad_n`;
  - latch `mem_we` = `tm1n` (tm1n=1 is a write);
  - decode size from `tm0n` and ad[1:0];
  - go to DATA.
- Size decode:
  - `tm0n`=1: byte; `mem_be` = 1 << ad[1:0].
  - `tm0n`=0, ad[1:0]=00: word, 1111.
  - `tm0n`=0, ad[1:0]=10: half, 1100.
  - `tm0n`=0, ad[1:0]=01: half, 0011.
  - `tm0n`=0, ad[1:0]=11: reserved; set the err flag and do not issue `mem_req`.
- DATA (one cycle):
  - latch `mem_wdata` = ~`ad_n`;
  - if no err flag, assert `mem_req`;
  - clear the wait counter;
  - go to WAIT.
- WAIT:
  - When `mem_done`=1: deassert `mem_req`, capture `mem_rdata` if reading, go to ACK with status COMPLETE.
  - With the err flag set: go to ACK with status ERROR immediately.
  - When the counter reaches `TIMEOUT`: deassert `mem_req`, go to ACK with status TIMEOUT.
- ACK (one cycle):
  - `ack_oe`=1 and `ack_out_n`=0;
  - `tm_oe`=1 and `tm_out_n` = status;
  - on reads, `ad_oe`=1 and `ad_out_n` = ~rdata (reads only, and only on COMPLETE);
  - `mem_ready`=1;
  - next state IDLE.
- Status codes on the active-low bus: COMPLETE = 2'b00, ERROR = 2'b01, TIMEOUT = 2'b10.
- Abort: if `slave`=0 in WAIT, return to IDLE the same edge. Drop `mem_req`; no ACK is driven.
- `mem_done` is ignored outside WAIT.
- A new START is ignored outside IDLE. A START seen with `ack_n`=0 is ignored.
- Counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.

## Timing
- Reset values:
  - state IDLE;
  - `mem_req`, `mem_we`, `mem_ready` = 0;
  - all `*_oe` = 0;
  - `ack_out_n`=1 and `tm_out_n`=2'b11;
  - `ad_out_n` = all ones;
  - `mem_addr`, `mem_wdata`, `mem_be` = 0.
- All outputs are registered. Reset mid-transfer drops every output asynchronously to its reset value.
- Edge 0 samples START. `mem_req` rises after edge 1. Earliest `mem_done` is sampled at edge 2. ACK is driven between edges 2 and 3. Minimum latency from START to ACK is 3 clocks.
- A `mem_done` arriving in the same cycle the counter reaches `TIMEOUT` takes priority; the status is COMPLETE.
- The slave controller sees `mem_ready` in the ACK cycle and clears SLAVE on the following edge.

## Structure
- Shared package `nubus_pkg`: the state enum, the status constants ST_COMPLETE/ST_ERROR/ST_TIMEOUT, and the size-decode function returning {err, be[3:0]}.
- One sub-module, `nubus_be_decode`: combinational decode of (`tm0n`, ad[1:0]) to byte enables plus err. It is reused by the master path.

## Test plan
- Word write, slot hit, addr 0xF0001000, data 0x12345678, `mem_done` in the first WAIT cycle:
  - `mem_be`=1111, `mem_we`=1;
  - ACK 3 clocks after START, `tm_out_n`=00, `mem_ready` high for one cycle.
- Byte read at addr 0xF0000003, `mem_rdata`=0xA5A5A5A5, `mem_done` after 5 waits: `mem_be`=1000; in the ACK cycle `ad_oe`=1 and `ad_out_n`=0x5A5A5A5A.
- `TIMEOUT`=4, `mem_done` never asserted: `mem_req` drops; ACK with `tm_out_n`=10 on the cycle after the 4th WAIT.
- Reserved size (`tm0n`=0, ad[1:0]=11): `mem_req` never rises; ACK with `tm_out_n`=01 at the minimum latency.
- START with `myslot`=0, and START with `ack_n`=0: no state change and no outputs.
- `slave` dropped in WAIT, and `reset` asserted in WAIT:
  - `slave` dropped: return to IDLE, `mem_req`=0, no ACK;
  - `reset`: all outputs immediately take their reset values.
